count_arbiter: RTL and testbench

- Shares one external 4-bit up-counter (inputs clk, rst, enable; output count) among NREQ requesters.
- Each requester asks the counter to advance by a requested number of ticks.
- The block grants requesters round-robin, drives the counter's enable for exactly that many clocks, and pulses a one-hot done to the winner.
- Sits between requesting agents and the shared counter instance. Never resets the counter; measures progress as a modulo distance from a latched base value.

---
 rtl/count_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_count_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : count_arbiter
// Description : Round-robin arbiter that lends one shared external up-counter
//               to NREQ requesters. The winner's requested tick count is
//               latched at grant. The counter enable is then driven until the
//               counter has advanced by that many ticks, and a one-cycle
//               one-hot done pulse goes to the winner. The counter is never
//               reset. Progress is measured as a modulo distance from the
//               count value latched at grant, so counter rollover is
//               transparent.
//
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-high reset
//               req        - per-requester request level [NREQ]
//               len        - per-requester tick count, requester i uses
//                            len[i*CW +: CW]
//               ctr_count  - live value of the shared counter [CW]
//               ctr_enable - enable to the shared counter
//               grant      - one-hot current owner, zero when idle [NREQ]
//               done       - one-hot one-cycle completion pulse [NREQ]
//               busy       - high while a job is running or completing
//               err        - one-cycle stall timeout pulse
//                            (present only with COUNT_ARB_TIMEOUT_EN)
//
// Options     : COUNT_ARB_TIMEOUT_EN - when defined, adds the err output.
//               A job is abandoned if the counter does not move for more
//               than TIMEOUT consecutive RUN cycles.
//
// Revision    : 1.0 - initial release
// ============================================================================
module count_arbiter #(
    parameter int NREQ    = 4,
    parameter int CW      = 4,
    parameter int TIMEOUT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    input  logic [CW-1:0]      ctr_count,
    output logic               ctr_enable,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy
`ifdef COUNT_ARB_TIMEOUT_EN
    ,
    output logic               err
`endif
);

    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREQ-1:0]   r_grant;
    logic [CW-1:0]     r_len;
    logic [CW-1:0]     r_base;
    logic [c_IW-1:0]   r_last;

    logic              w_any;
    logic [c_IW-1:0]   w_win;
    logic [NREQ-1:0]   w_win_oh;
    logic [CW-1:0]     w_len_win;
    logic [CW-1:0]     w_elapsed;
    logic              w_owner_req;
    logic              w_load;
    logic              w_timeout;

    // Index of the requester 'step' positions after 'last', wrapping at NREQ.
    function automatic logic [c_IW-1:0] rr_idx(input logic [c_IW-1:0] last,
                                               input int step);
        return c_IW'((int'(last) + step) % NREQ);
    endfunction

    // Round-robin search: start just after the previous winner so the most
    // recently served requester has the lowest priority.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!w_any && req[rr_idx(r_last, i)]) begin
                w_any = 1'b1;
                w_win = rr_idx(r_last, i);
            end
        end
    end

    assign w_win_oh    = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign w_len_win   = len[w_win*CW +: CW];
    // Ticks delivered so far; modulo arithmetic hides counter rollover.
    assign w_elapsed   = ctr_count - r_base;
    assign w_owner_req = |(req & r_grant);

`ifdef COUNT_ARB_TIMEOUT_EN
    localparam int c_SW = $clog2(TIMEOUT + 2);

    logic [CW-1:0]     r_prev_count;
    logic [c_SW-1:0]   r_stall;
    logic [c_SW-1:0]   w_stall_nxt;
    logic              r_err;
    logic              w_stall_trip;

    // Stall run length, saturating just above the limit. It is held at zero
    // outside RUN, so it starts clean on every entry to RUN. The first RUN
    // cycle always compares equal because the previous sample was the base.
    always_comb begin
        w_stall_nxt = '0;
        if (r_state == ST_RUN && ctr_count == r_prev_count) begin
            if (r_stall == c_SW'(TIMEOUT + 1)) begin
                w_stall_nxt = r_stall;
            end else begin
                w_stall_nxt = r_stall + c_SW'(1);
            end
        end
    end

    assign w_stall_trip = (w_stall_nxt > c_SW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_count <= '0;
            r_stall      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_prev_count <= ctr_count;
            r_stall      <= w_stall_nxt;
            r_err        <= w_timeout;
        end
    end

    assign err = r_err;
`else
    logic w_stall_trip;
    assign w_stall_trip = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = (w_len_win == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // The enable is high in this cycle, so reaching L-1 here
                // means the counter takes its L-th tick on this edge.
                if (!w_owner_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_elapsed == r_len - CW'(1)) begin
                    w_state_nxt = ST_DONE;
                end else if (w_stall_trip) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and job registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_len   <= '0;
            r_base  <= '0;
            r_last  <= c_IW'(NREQ - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_grant <= w_win_oh;
                r_len   <= w_len_win;
                r_base  <= ctr_count;
                r_last  <= w_win;
            end else if (w_state_nxt == ST_IDLE) begin
                r_grant <= '0;
            end
        end
    end

    assign ctr_enable = (r_state == ST_RUN);
    assign busy       = (r_state != ST_IDLE);
    assign grant      = r_grant;
    assign done       = (r_state == ST_DONE) ? r_grant : '0;

endmodule
`default_nettype wire

// File: tb/tb_count_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_arbiter
// Description : Self-checking bench for count_arbiter. A behavioural model of
//               the shared counter is driven by ctr_enable. Expected jobs
//               (winner, tick count, final counter value) are queued as
//               stimulus is applied. Each done pulse is checked against the
//               oldest queued job.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_arbiter;

    localparam int NREQ    = 4;
    localparam int CW      = 4;
    localparam int TIMEOUT = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [CW-1:0]      cnt;
    logic               ctr_enable;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
`ifdef COUNT_ARB_TIMEOUT_EN
    logic               err;
`endif

    logic               hold;
    logic               preset;
    logic [CW-1:0]      preset_val;

    typedef struct {
        int            idx;
        int            len;
        logic [CW-1:0] count;
    } job_t;

    job_t sb[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   en_cnt = 0;

    count_arbiter #(
        .NREQ    (NREQ),
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .len        (len),
        .ctr_count  (cnt),
        .ctr_enable (ctr_enable),
        .grant      (grant),
        .done       (done),
        .busy       (busy)
`ifdef COUNT_ARB_TIMEOUT_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    // Shared counter model: never reset. It can be preset, or frozen to
    // model a stalled counter.
    always @(posedge clk) begin
        if (preset) begin
            cnt <= preset_val;
        end else if (ctr_enable && !hold) begin
            cnt <= cnt + 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest expected job.
    always @(negedge clk) begin
        job_t j;
        if (!busy) begin
            en_cnt = 0;
        end else if (ctr_enable) begin
            en_cnt++;
        end
        if (done != '0) begin
            if (sb.size() == 0) begin
                check("unexp_done", 32'(done), 32'd0);
            end else begin
                j = sb.pop_front();
                check("done_vec",   32'(done),  32'(1) << j.idx);
                check("grant_hold", 32'(grant), 32'(1) << j.idx);
                check("end_count",  32'(cnt),   32'(j.count));
                check("en_cycles",  32'(en_cnt), 32'(j.len));
            end
        end
    end

    task automatic preset_count(input logic [CW-1:0] v);
        @(negedge clk);
        preset     = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset     = 1'b0;
    endtask

    // Counts negedges until a done pulse is seen, bounded by 'limit'.
    task automatic wait_done(input int limit, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (done != '0) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int            cyc;
        logic [CW-1:0] base;
        logic [CW-1:0] saved;

        rst        = 1'b1;
        req        = '0;
        len        = '0;
        hold       = 1'b0;
        preset     = 1'b0;
        preset_val = '0;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_en",    32'(ctr_enable), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        rst = 1'b0;
        preset_count(4'd0);

        // Single job, len 5 from count 0
        len[0 +: CW] = 4'd5;
        req          = 4'b0001;
        sb.push_back('{idx: 0, len: 5, count: 4'd5});
        @(negedge clk);
        check("first_en",    32'(ctr_enable), 32'd1);
        check("first_grant", 32'(grant), 32'd1);
        wait_done(20, cyc);
        check("lat_done5", 32'(cyc), 32'd5);
        req = '0;
        @(negedge clk);
        check("grant_clr", 32'(grant), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Rollover: 13 + 6 ticks wraps to 3
        preset_count(4'd13);
        len[0 +: CW] = 4'd6;
        req          = 4'b0001;
        sb.push_back('{idx: 0, len: 6, count: 4'd3});
        wait_done(30, cyc);
        check("lat_wrap", 32'(cyc), 32'd7);
        req = '0;
        @(negedge clk);

        // Round robin after reset: all requesting, len 1 each
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        base = cnt;
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{idx: k % NREQ, len: 1, count: base + CW'(k + 1)});
        end
        len = {NREQ{4'd1}};
        req = 4'b1111;
        wait_done(10, cyc);
        check("rr_first", 32'(cyc), 32'd2);
        for (int k = 1; k < 5; k++) begin
            wait_done(10, cyc);
            check("rr_gap", 32'(cyc), 32'd3);
        end
        req = '0;
        @(negedge clk);

        // Zero-length job: done with no enable, counter unchanged
        len = '0;
        req = 4'b0001;
        sb.push_back('{idx: 0, len: 0, count: cnt});
        wait_done(10, cyc);
        check("lat_len0", 32'(cyc), 32'd1);
        req = '0;
        @(negedge clk);

        // Abort: drop req2 after three enable cycles
        base              = cnt;
        len[2*CW +: CW]   = 4'd9;
        req               = 4'b0100;
        repeat (3) @(negedge clk);
        check("abort_run_en", 32'(ctr_enable), 32'd1);
        req = '0;
        @(negedge clk);
        check("abort_en",    32'(ctr_enable), 32'd0);
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_cnt",   32'(cnt), 32'(CW'(base + CW'(3))));

        // Asynchronous reset in the middle of a job
        len[CW +: CW] = 4'd9;
        req           = 4'b0010;
        repeat (3) @(negedge clk);
        check("pre_rst_grant", 32'(grant), 32'd2);
        #2;
        saved = cnt;
        rst   = 1'b1;
        #1;
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_en",    32'(ctr_enable), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_done",  32'(done), 32'd0);
        check("arst_cnt",   32'(cnt), 32'(saved));
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

`ifdef COUNT_ARB_TIMEOUT_EN
        // Stalled counter: err after four stalled RUN cycles, no done
        begin
            logic seen;
            hold          = 1'b1;
            len[CW +: CW] = 4'd7;
            req           = 4'b0010;
            seen          = 1'b0;
            cyc           = 0;
            while (!seen && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (err) seen = 1'b1;
            end
            if (!seen) check("err_timeout", 32'd0, 32'd1);
            check("err_lat",  32'(cyc), 32'd5);
            check("err_busy", 32'(busy), 32'd0);
            check("err_en",   32'(ctr_enable), 32'd0);
            req = '0;
            @(negedge clk);
            check("err_pulse", 32'(err), 32'd0);
            check("err_idle",  32'(busy), 32'd0);
            hold = 1'b0;
        end
`endif

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
